// File: rtl/excp_pkg.sv
// Shared definitions for the writeback exception/ERTN commit sequencer:
// Ecode constants, sequencer state encoding and event classification.
package excp_pkg;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SAVE  = 2'd1,
    ST_REDIR = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_INT  = 2'd1,
    EV_EXC  = 2'd2,
    EV_ERTN = 2'd3
  } ev_kind_e;

  // Interrupts win over synchronous exceptions, which win over ERTN.
  function automatic ev_kind_e classify(input logic int_pend, input logic excp, input logic ertn);
    ev_kind_e k;
    if (int_pend)  k = EV_INT;
    else if (excp) k = EV_EXC;
    else if (ertn) k = EV_ERTN;
    else           k = EV_NONE;
    return k;
  endfunction

endpackage

// File: rtl/wb_excp_commit.sv
// Writeback-stage exception/interrupt/ERTN commit sequencer: latches the
// event, strobes the CSR save/restore for one cycle, then redirects IF.
module wb_excp_commit
  import excp_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int ECODE_W = 6,
  parameter int ESUB_W  = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wb_valid_i,
  input  logic               wb_excp_i,
  input  logic               wb_ertn_i,
  input  logic [ECODE_W-1:0] wb_ecode_i,
  input  logic [ESUB_W-1:0]  wb_esubcode_i,
  input  logic [PC_W-1:0]    wb_pc_i,
  input  logic               wb_badv_vld_i,
  input  logic [PC_W-1:0]    wb_badv_i,
  input  logic               int_pending_i,
  input  logic [PC_W-1:0]    csr_eentry_i,
  input  logic [PC_W-1:0]    csr_era_i,
  input  logic               if_redirect_ready_i,
  output logic               wb_ready_o,
  output logic               wb_rf_kill_o,
  output logic               csr_excp_we_o,
  output logic               csr_ertn_we_o,
  output logic [ECODE_W-1:0] csr_ecode_o,
  output logic [ESUB_W-1:0]  csr_esubcode_o,
  output logic [PC_W-1:0]    csr_era_wdata_o,
  output logic               csr_badv_we_o,
  output logic [PC_W-1:0]    csr_badv_wdata_o,
  output logic               redirect_valid_o,
  output logic [PC_W-1:0]    redirect_pc_o,
  output logic               excp_commit_o
);

  state_e             state_q, state_d;
  ev_kind_e           kind_q, kind_d;
  logic [ECODE_W-1:0] ecode_q, ecode_d;
  logic [ESUB_W-1:0]  esub_q, esub_d;
  logic [PC_W-1:0]    era_q, era_d;
  logic [PC_W-1:0]    badv_q, badv_d;
  logic               badv_vld_q, badv_vld_d;
  logic [PC_W-1:0]    rpc_q, rpc_d;

  ev_kind_e           ev_s;
  logic               trig_s;

  assign ev_s   = classify(int_pending_i, wb_excp_i, wb_ertn_i);
  assign trig_s = wb_valid_i & (ev_s != EV_NONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      kind_q     <= EV_NONE;
      ecode_q    <= '0;
      esub_q     <= '0;
      era_q      <= '0;
      badv_q     <= '0;
      badv_vld_q <= 1'b0;
      rpc_q      <= '0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      ecode_q    <= ecode_d;
      esub_q     <= esub_d;
      era_q      <= era_d;
      badv_q     <= badv_d;
      badv_vld_q <= badv_vld_d;
      rpc_q      <= rpc_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    kind_d           = kind_q;
    ecode_d          = ecode_q;
    esub_d           = esub_q;
    era_d            = era_q;
    badv_d           = badv_q;
    badv_vld_d       = badv_vld_q;
    rpc_d            = rpc_q;
    wb_ready_o       = 1'b0;
    wb_rf_kill_o     = 1'b0;
    csr_excp_we_o    = 1'b0;
    csr_ertn_we_o    = 1'b0;
    csr_badv_we_o    = 1'b0;
    redirect_valid_o = 1'b0;
    excp_commit_o    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        wb_ready_o   = ~trig_s;
        wb_rf_kill_o = wb_valid_i & (int_pending_i | wb_excp_i);
        if (trig_s) begin
          kind_d  = ev_s;
          state_d = ST_SAVE;
          case (ev_s)
            EV_INT: begin
              ecode_d    = ECODE_W'(ECODE_INT);
              esub_d     = '0;
              era_d      = wb_pc_i;
              badv_vld_d = 1'b0;
            end
            EV_EXC: begin
              ecode_d    = wb_ecode_i;
              esub_d     = wb_esubcode_i;
              era_d      = wb_pc_i;
              badv_vld_d = wb_badv_vld_i;
              badv_d     = wb_badv_vld_i ? wb_badv_i : badv_q;
            end
            // ERTN leaves ESTAT/ERA/BADV holding values untouched.
            default: badv_vld_d = 1'b0;
          endcase
        end
      end
      ST_SAVE: begin
        csr_excp_we_o = (kind_q != EV_ERTN);
        csr_ertn_we_o = (kind_q == EV_ERTN);
        csr_badv_we_o = (kind_q == EV_EXC) & badv_vld_q;
        rpc_d         = (kind_q == EV_ERTN) ? csr_era_i : csr_eentry_i;
        state_d       = ST_REDIR;
      end
      ST_REDIR: begin
        redirect_valid_o = 1'b1;
        excp_commit_o    = if_redirect_ready_i;
        if (if_redirect_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign csr_ecode_o      = ecode_q;
  assign csr_esubcode_o   = esub_q;
  assign csr_era_wdata_o  = era_q;
  assign csr_badv_wdata_o = badv_q;
  assign redirect_pc_o    = rpc_q;

endmodule

// File: tb/tb_wb_excp_commit.sv
// Randomized scoreboard bench for wb_excp_commit: the driver predicts each
// event from the priority rules and a monitor checks the CSR/redirect outputs.
module tb_wb_excp_commit;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, wb_excp, wb_ertn, wb_badv_vld, int_pending, if_redirect_ready;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc, wb_badv, csr_eentry, csr_era;
  logic        wb_ready, wb_rf_kill, csr_excp_we, csr_ertn_we, csr_badv_we;
  logic        redirect_valid, excp_commit;
  logic [5:0]  csr_ecode;
  logic [8:0]  csr_esubcode;
  logic [31:0] csr_era_wdata, csr_badv_wdata, redirect_pc;

  always #5 clk = ~clk;

  wb_excp_commit dut (
    .clk(clk), .reset(reset),
    .wb_valid_i(wb_valid), .wb_excp_i(wb_excp), .wb_ertn_i(wb_ertn),
    .wb_ecode_i(wb_ecode), .wb_esubcode_i(wb_esubcode), .wb_pc_i(wb_pc),
    .wb_badv_vld_i(wb_badv_vld), .wb_badv_i(wb_badv), .int_pending_i(int_pending),
    .csr_eentry_i(csr_eentry), .csr_era_i(csr_era), .if_redirect_ready_i(if_redirect_ready),
    .wb_ready_o(wb_ready), .wb_rf_kill_o(wb_rf_kill),
    .csr_excp_we_o(csr_excp_we), .csr_ertn_we_o(csr_ertn_we),
    .csr_ecode_o(csr_ecode), .csr_esubcode_o(csr_esubcode), .csr_era_wdata_o(csr_era_wdata),
    .csr_badv_we_o(csr_badv_we), .csr_badv_wdata_o(csr_badv_wdata),
    .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc), .excp_commit_o(excp_commit)
  );

  typedef struct {
    int          kind;  // 1 interrupt, 2 exception, 3 ERTN
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] era;
    logic        badv_we;
    logic [31:0] badv;
  } save_t;

  save_t       save_q[$];
  logic [31:0] commit_q[$];
  int          pass_cnt = 0;
  int          chk_cnt  = 0;

  // Values the CSR data outputs should currently be holding.
  logic [5:0]  last_ecode = 6'h00;
  logic [8:0]  last_esub  = 9'h000;
  logic [31:0] last_era   = 32'h0;
  logic [31:0] last_badv  = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int kind_of(input logic i, input logic e, input logic r);
    if (i) return 1;
    if (e) return 2;
    if (r) return 3;
    return 0;
  endfunction

  task automatic zero_wb();
    wb_valid = 1'b0; wb_excp = 1'b0; wb_ertn = 1'b0; int_pending = 1'b0;
    wb_ecode = 6'h00; wb_esubcode = 9'h000; wb_pc = 32'h0;
    wb_badv_vld = 1'b0; wb_badv = 32'h0;
  endtask

  task automatic garbage_wb();
    wb_valid = 1'($urandom); wb_excp = 1'($urandom); wb_ertn = 1'($urandom);
    int_pending = 1'($urandom); wb_ecode = 6'($urandom); wb_esubcode = 9'($urandom);
    wb_pc = $urandom; wb_badv_vld = 1'($urandom); wb_badv = $urandom;
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle.
  task automatic issue(input logic v, input logic i, input logic e, input logic r,
                       input logic [5:0] ec, input logic [8:0] es, input logic [31:0] pc,
                       input logic bv, input logic [31:0] bad,
                       input logic [31:0] ee, input logic [31:0] er,
                       input int lat, input bit rst_in_redir);
    int          k;
    bit          trig;
    save_t       s;
    logic [31:0] exp_pc;
    k    = kind_of(i, e, r);
    trig = v && (k != 0);
    wb_valid = v; int_pending = i; wb_excp = e; wb_ertn = r;
    wb_ecode = ec; wb_esubcode = es; wb_pc = pc; wb_badv_vld = bv; wb_badv = bad;
    csr_eentry = ee; csr_era = er; if_redirect_ready = 1'($urandom);
    @(negedge clk);
    check("idle_wb_ready", wb_ready, !trig);
    check("idle_rf_kill", wb_rf_kill, v & (i | e));
    check("idle_redirect_valid", redirect_valid, 1'b0);
    if (!trig) begin
      @(posedge clk); #1;
      return;
    end
    if (k == 1) begin
      last_ecode = 6'h00; last_esub = 9'h000; last_era = pc;
    end else if (k == 2) begin
      last_ecode = ec; last_esub = es; last_era = pc;
      if (bv) last_badv = bad;
    end
    s.kind = k; s.ecode = last_ecode; s.esub = last_esub; s.era = last_era;
    s.badv_we = (k == 2) && bv; s.badv = last_badv;
    save_q.push_back(s);
    exp_pc = (k == 3) ? er : ee;
    commit_q.push_back(exp_pc);

    @(posedge clk); #1;
    garbage_wb();
    if_redirect_ready = 1'($urandom);
    @(negedge clk);
    check("save_excp_we", csr_excp_we, k != 3);
    check("save_ertn_we", csr_ertn_we, k == 3);
    check("save_wb_ready", wb_ready, 1'b0);
    check("save_redirect_valid", redirect_valid, 1'b0);

    @(posedge clk); #1;
    csr_eentry = $urandom; csr_era = $urandom;
    if (rst_in_redir) begin
      reset = 1'b1; if_redirect_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      zero_wb();
      void'(commit_q.pop_back());
      last_ecode = 6'h00; last_esub = 9'h000; last_era = 32'h0; last_badv = 32'h0;
      @(negedge clk);
      check("rst_redirect_valid", redirect_valid, 1'b0);
      check("rst_excp_commit", excp_commit, 1'b0);
      check("rst_wb_ready", wb_ready, 1'b1);
      check("rst_csr_ecode", csr_ecode, last_ecode);
      check("rst_redirect_pc", redirect_pc, 32'h0);
      @(posedge clk); #1;
      return;
    end
    for (int c = 0; c <= lat; c++) begin
      if_redirect_ready = (c == lat);
      garbage_wb();
      @(negedge clk);
      check("redir_valid", redirect_valid, 1'b1);
      check("redir_wb_ready", wb_ready, 1'b0);
      check("redir_pc_held", redirect_pc, exp_pc);
      check("redir_commit", excp_commit, c == lat);
      check("redir_no_strobe", csr_excp_we | csr_ertn_we | csr_badv_we, 1'b0);
      @(posedge clk); #1;
    end
    zero_wb();
  endtask

  // Scoreboard monitor: pairs every CSR strobe and every commit with its prediction.
  always @(negedge clk) begin
    save_t       s;
    logic [31:0] p;
    if (!reset) begin
      if (csr_excp_we || csr_ertn_we) begin
        check("strobe_expected", save_q.size() != 0, 1'b1);
        if (save_q.size() != 0) begin
          s = save_q.pop_front();
          check("sb_ertn_we", csr_ertn_we, s.kind == 3);
          check("sb_ecode", csr_ecode, s.ecode);
          check("sb_esub", csr_esubcode, s.esub);
          check("sb_era", csr_era_wdata, s.era);
          check("sb_badv_we", csr_badv_we, s.badv_we);
          check("sb_badv", csr_badv_wdata, s.badv);
        end
      end else begin
        check("sb_badv_we_idle", csr_badv_we, 1'b0);
      end
      if (excp_commit) begin
        check("commit_expected", commit_q.size() != 0, 1'b1);
        if (commit_q.size() != 0) begin
          p = commit_q.pop_front();
          check("sb_redirect_pc", redirect_pc, p);
        end
      end
    end
  end

  logic [5:0] ecl [5] = '{6'h08, 6'h09, 6'h0B, 6'h0C, 6'h0D};

  initial begin
    reset = 1'b1;
    zero_wb();
    csr_eentry = 32'h0; csr_era = 32'h0; if_redirect_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_wb_ready", wb_ready, 1'b1);
    check("reset_strobes", {csr_excp_we, csr_ertn_we, csr_badv_we, redirect_valid, excp_commit, wb_rf_kill}, 6'b0);
    check("reset_data", {csr_ecode, csr_esubcode, csr_era_wdata, csr_badv_wdata}, 79'h0);
    check("reset_redirect_pc", redirect_pc, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // SYS, ERTN, stalled redirect, interrupt over ADEF, ALE with BADV, reset in REDIR
    issue(1'b1, 1'b0, 1'b1, 1'b0, 6'h0B, 9'h000, 32'h1C000100, 1'b0, 32'h0, 32'h1C008000, 32'h0, 0, 1'b0);
    issue(1'b1, 1'b0, 1'b0, 1'b1, 6'h00, 9'h000, 32'h1C000200, 1'b0, 32'h0, 32'h1C008000, 32'h1C000104, 0, 1'b0);
    issue(1'b1, 1'b0, 1'b1, 1'b0, 6'h0B, 9'h000, 32'h1C000300, 1'b0, 32'h0, 32'h1C008000, 32'h0, 3, 1'b0);
    issue(1'b1, 1'b1, 1'b1, 1'b0, 6'h08, 9'h001, 32'h1C000400, 1'b1, 32'h1C0000AA, 32'h1C008000, 32'h0, 0, 1'b0);
    issue(1'b1, 1'b0, 1'b1, 1'b0, 6'h09, 9'h000, 32'h1C000500, 1'b1, 32'h1C0000FE, 32'h1C008000, 32'h0, 0, 1'b0);
    issue(1'b1, 1'b0, 1'b1, 1'b0, 6'h0C, 9'h000, 32'h1C000600, 1'b0, 32'h0, 32'h1C008000, 32'h0, 2, 1'b1);
    issue(1'b1, 1'b0, 1'b0, 1'b0, 6'h0D, 9'h000, 32'h1C000700, 1'b0, 32'h0, 32'h1C008000, 32'h0, 0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      issue(($urandom % 4) != 0, ($urandom % 5) == 0, ($urandom % 2) == 0, ($urandom % 3) == 0,
            ecl[$urandom % 5], 9'($urandom), $urandom, 1'($urandom), $urandom,
            $urandom, $urandom, int'($urandom % 4), ($urandom % 10) == 0);
    end

    @(negedge clk);
    check("save_q_drained", save_q.size(), 0);
    check("commit_q_drained", commit_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
